// File: rtl/float_types_pkg.sv
// Shared IEEE-754 single-precision types, constants and classification helpers
// for the floating-point summator/subtractor family.
package float_types_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned MANT_W  = 27;
    localparam int unsigned EXPS_W  = 10;
    localparam int unsigned FP_BIAS = 127;

    localparam logic [EXP_W-1:0] FP_EXP_MAX = 8'hFF;
    localparam logic [FP_W-1:0]  FP_QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float_point_num;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ZERO = 2'd1,
        ST_OVF  = 2'd2,
        ST_NAN  = 2'd3
    } fp_status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPEC  = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_ROUND = 3'd5,
        S_DONE  = 3'd6
    } sub_state_e;

    function automatic logic fp_is_nan(input float_point_num f);
        return (f.exp == FP_EXP_MAX) && (f.frac != '0);
    endfunction

    function automatic logic fp_is_inf(input float_point_num f);
        return (f.exp == FP_EXP_MAX) && (f.frac == '0);
    endfunction

    // Denormals are treated as zero.
    function automatic logic fp_is_zero(input float_point_num f);
        return (f.exp == '0);
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised 27-bit mantissa (hidden, frac, G, R, S)
// with exponent correction and overflow detection.
module fp_round_rne
    import float_types_pkg::*;
(
    input  logic [MANT_W-1:0]        i_mant,
    input  logic signed [EXPS_W-1:0] i_exp,
    output logic [FRAC_W-1:0]        o_frac,
    output logic [EXP_W-1:0]         o_exp,
    output logic                     o_ovf
);
    localparam int unsigned RND_W = FRAC_W + 2;

    logic                     w_lsb;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_up;
    logic [RND_W-1:0]         w_rnd;
    logic signed [EXPS_W-1:0] w_exp;

    assign w_lsb    = i_mant[3];
    assign w_guard  = i_mant[2];
    assign w_sticky = i_mant[1] | i_mant[0];
    assign w_up     = w_guard & (w_sticky | w_lsb);

    // A carry out of the rounded mantissa means 1.111..1 became 10.000..0
    assign w_rnd  = {1'b0, i_mant[MANT_W-1:3]} + RND_W'(w_up);
    assign w_exp  = i_exp + $signed(EXPS_W'(w_rnd[RND_W-1]));
    assign o_frac = w_rnd[RND_W-1] ? w_rnd[FRAC_W:1] : w_rnd[FRAC_W-1:0];
    assign o_exp  = w_exp[EXP_W-1:0];
    assign o_ovf  = (w_exp >= $signed(EXPS_W'(FP_EXP_MAX)));

endmodule

// File: rtl/seq_fp_subtractor.sv
// Multi-cycle single-precision subtractor (a - b) behind valid/ready handshakes;
// aligns and normalises one bit per cycle.
module seq_fp_subtractor
    import float_types_pkg::*;
#(
    parameter int unsigned ALIGN_MAX = 26
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           vld_i,
    output logic           rdy_o,
    input  float_point_num a_i,
    input  float_point_num b_i,
    output logic           vld_o,
    input  logic           rdy_i,
    output float_point_num answer_o,
    output fp_status_e     answer_status_o
);
    localparam int unsigned D_W = $clog2(ALIGN_MAX + 2);

    sub_state_e               r_state;
    float_point_num           r_a;
    float_point_num           r_b;
    logic                     r_sign_x;
    logic                     r_sub;
    logic signed [EXPS_W-1:0] r_exp;
    logic [MANT_W-1:0]        r_mx;
    logic [MANT_W-1:0]        r_my;
    logic [MANT_W:0]          r_sum;
    logic [D_W-1:0]           r_d;
    logic                     r_rdy;
    logic                     r_vld;
    float_point_num           r_answer;
    fp_status_e               r_status;

    logic                     w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    float_point_num           w_af, w_bf, w_x, w_y;
    logic                     w_swap;
    logic [EXPS_W-1:0]        w_exp_diff;
    logic [D_W-1:0]           w_d;
    logic [MANT_W-1:0]        w_mx, w_my;
    logic [MANT_W:0]          w_sum;
    logic [FRAC_W-1:0]        w_rnd_frac;
    logic [EXP_W-1:0]         w_rnd_exp;
    logic                     w_rnd_ovf;

    // Operand classification on the registered (b-negated) operands
    assign w_a_nan  = fp_is_nan(r_a);
    assign w_b_nan  = fp_is_nan(r_b);
    assign w_a_inf  = fp_is_inf(r_a);
    assign w_b_inf  = fp_is_inf(r_b);
    assign w_a_zero = fp_is_zero(r_a);
    assign w_b_zero = fp_is_zero(r_b);

    assign w_af = w_a_zero ? float_point_num'({r_a.sign, 31'b0}) : r_a;
    assign w_bf = w_b_zero ? float_point_num'({r_b.sign, 31'b0}) : r_b;

    // x is the operand of larger magnitude, y gets aligned to it
    assign w_swap     = {w_bf.exp, w_bf.frac} > {w_af.exp, w_af.frac};
    assign w_x        = w_swap ? w_bf : w_af;
    assign w_y        = w_swap ? w_af : w_bf;
    assign w_exp_diff = EXPS_W'(w_x.exp) - EXPS_W'(w_y.exp);
    assign w_d        = (w_exp_diff > EXPS_W'(ALIGN_MAX)) ? D_W'(ALIGN_MAX + 1)
                                                          : D_W'(w_exp_diff);
    assign w_mx       = {(w_x.exp != '0), w_x.frac, 3'b000};
    assign w_my       = {(w_y.exp != '0), w_y.frac, 3'b000};

    assign w_sum = r_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                         : ({1'b0, r_mx} + {1'b0, r_my});

    fp_round_rne u_round (
        .i_mant (r_sum[MANT_W-1:0]),
        .i_exp  (r_exp),
        .o_frac (w_rnd_frac),
        .o_exp  (w_rnd_exp),
        .o_ovf  (w_rnd_ovf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sign_x <= 1'b0;
            r_sub    <= 1'b0;
            r_exp    <= '0;
            r_mx     <= '0;
            r_my     <= '0;
            r_sum    <= '0;
            r_d      <= '0;
            r_rdy    <= 1'b1;
            r_vld    <= 1'b0;
            r_answer <= '0;
            r_status <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (vld_i && r_rdy) begin
                        r_a     <= a_i;
                        r_b     <= {~b_i.sign, b_i.exp, b_i.frac};
                        r_rdy   <= 1'b0;
                        r_state <= S_SPEC;
                    end
                end

                S_SPEC: begin
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a.sign != r_b.sign))) begin
                        r_answer <= float_point_num'(FP_QNAN);
                        r_status <= ST_NAN;
                        r_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_a_inf) begin
                        r_answer <= r_a;
                        r_status <= ST_OVF;
                        r_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_b_inf) begin
                        r_answer <= r_b;
                        r_status <= ST_OVF;
                        r_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_a_zero && w_b_zero) begin
                        r_answer <= '0;
                        r_status <= ST_ZERO;
                        r_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_sign_x <= w_x.sign;
                        r_sub    <= r_a.sign ^ r_b.sign;
                        r_exp    <= $signed({2'b00, w_x.exp});
                        r_mx     <= w_mx;
                        r_my     <= w_my;
                        r_d      <= w_d;
                        r_state  <= (w_d == '0) ? S_ADD : S_ALIGN;
                    end
                end

                // Beyond ALIGN_MAX every bit of y lands below S, so only its OR survives
                S_ALIGN: begin
                    if (r_d > D_W'(ALIGN_MAX)) begin
                        r_my    <= {{(MANT_W-1){1'b0}}, |r_my};
                        r_d     <= '0;
                        r_state <= S_ADD;
                    end else begin
                        r_my <= {1'b0, r_my[MANT_W-1:2], r_my[1] | r_my[0]};
                        r_d  <= r_d - D_W'(1);
                        if (r_d == D_W'(1)) begin
                            r_state <= S_ADD;
                        end
                    end
                end

                S_ADD: begin
                    if (w_sum == '0) begin
                        r_answer <= '0;
                        r_status <= ST_ZERO;
                        r_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_sum   <= w_sum;
                        r_state <= (w_sum[MANT_W] || !w_sum[MANT_W-1]) ? S_NORM : S_ROUND;
                    end
                end

                S_NORM: begin
                    if (r_sum[MANT_W]) begin
                        r_sum   <= {1'b0, r_sum[MANT_W:2], r_sum[1] | r_sum[0]};
                        r_exp   <= r_exp + 10'sd1;
                        r_state <= S_ROUND;
                    end else if (r_exp == 10'sd1) begin
                        // Next left shift would produce a denormal: flush
                        r_answer <= float_point_num'({r_sign_x, 31'b0});
                        r_status <= ST_ZERO;
                        r_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_sum <= {r_sum[MANT_W-1:0], 1'b0};
                        r_exp <= r_exp - 10'sd1;
                        if (r_sum[MANT_W-2]) begin
                            r_state <= S_ROUND;
                        end
                    end
                end

                S_ROUND: begin
                    if (w_rnd_ovf) begin
                        r_answer <= {r_sign_x, FP_EXP_MAX, {FRAC_W{1'b0}}};
                        r_status <= ST_OVF;
                    end else begin
                        r_answer <= {r_sign_x, w_rnd_exp, w_rnd_frac};
                        r_status <= ST_OK;
                    end
                    r_vld   <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    if (rdy_i) begin
                        r_vld   <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_vld   <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdy_o           = r_rdy;
    assign vld_o           = r_vld;
    assign answer_o        = r_answer;
    assign answer_status_o = r_status;

endmodule

// File: tb/tb_seq_fp_subtractor.sv
// Self-checking bench for seq_fp_subtractor: directed cases, randomized operands
// against a real-arithmetic reference, output hold, and mid-operation reset.
module tb_seq_fp_subtractor;
    import float_types_pkg::*;

    localparam int LAT_LIMIT = 100;
    localparam int LAT_MAX   = 4 + 26 + 24;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        vld_i;
    logic        rdy_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        vld_o;
    logic        rdy_i;
    logic [31:0] answer_o;
    fp_status_e  answer_status_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_fp_subtractor #(.ALIGN_MAX(26)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .vld_i           (vld_i),
        .rdy_o           (rdy_o),
        .a_i             (a_i),
        .b_i             (b_i),
        .vld_o           (vld_o),
        .rdy_i           (rdy_i),
        .answer_o        (answer_o),
        .answer_status_o (answer_status_o)
    );

    // Single-precision value as an exact double; denormals read as zero
    function automatic real to_real(input logic [31:0] bits);
        float_point_num f;
        f = bits;
        if (f.exp == 8'h00) return 0.0;
        return $bitstoreal({f.sign, 11'(int'(f.exp) - int'(FP_BIAS) + 1023), f.frac, 29'b0});
    endfunction

    // Reference: special-value rules, then a - b in double rounded once more to
    // single with RNE (double is wide enough that the double rounding is exact).
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output fp_status_e st);
        float_point_num fa, fb;
        real            df;
        logic [63:0]    db;
        logic [52:0]    m;
        logic [24:0]    k;
        int             e;
        fa = a;
        fb = b;
        if ((fa.exp == 8'hFF && fa.frac != 0) || (fb.exp == 8'hFF && fb.frac != 0)) begin
            r = FP_QNAN; st = ST_NAN;
        end else if (fa.exp == 8'hFF && fb.exp == 8'hFF) begin
            if (fa.sign == fb.sign) begin r = FP_QNAN; st = ST_NAN; end
            else begin r = a; st = ST_OVF; end
        end else if (fa.exp == 8'hFF) begin
            r = a; st = ST_OVF;
        end else if (fb.exp == 8'hFF) begin
            r = {~fb.sign, fb.exp, fb.frac}; st = ST_OVF;
        end else begin
            df = to_real(a) - to_real(b);
            if (df == 0.0) begin
                r = 32'h0; st = ST_ZERO;
            end else begin
                db = $realtobits(df);
                e  = int'(db[62:52]) - 1023;
                m  = {1'b1, db[51:0]};
                k  = {1'b0, m[52:29]};
                if (m[28] && ((|m[27:0]) || k[0])) k = k + 25'd1;
                if (k[24]) begin k = k >> 1; e = e + 1; end
                if (e + 127 >= 255) begin
                    r = {db[63], 8'hFF, 23'h0}; st = ST_OVF;
                end else if (e + 127 <= 0) begin
                    r = {db[63], 31'h0}; st = ST_ZERO;
                end else begin
                    r = {db[63], 8'(e + 127), k[22:0]}; st = ST_OK;
                end
            end
        end
    endfunction

    // Present operands, wait for vld_o; lat counts edges including the accept edge
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ans, output fp_status_e st, output int lat);
        a_i   = a;
        b_i   = b;
        vld_i = 1'b1;
        @(posedge clk); #1;
        vld_i = 1'b0;
        lat   = 1;
        while (vld_o !== 1'b1 && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        ans = answer_o;
        st  = answer_status_o;
    endtask

    task automatic release_result();
        rdy_i = 1'b1;
        @(posedge clk); #1;
        rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", rdy_o); end
        n_tests++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld_o); end
        n_tests++; if (answer_o !== 32'h0) begin n_fail++; $display("FAIL reset_answer: got %h expected 00000000", answer_o); end
        n_tests++; if (answer_status_o !== ST_OK) begin n_fail++; $display("FAIL reset_status: got %0d expected %0d", answer_status_o, ST_OK); end
        rst_i = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (rdy_o !== 1'b1 || vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got rdy=%b vld=%b expected rdy=1 vld=0", rdy_o, vld_o); end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        fp_status_e  st;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v[10];
        logic [31:0] ans;
        fp_status_e  st;
        int          lat;
        v[0] = '{32'h4044CCCD, 32'h400CCCCD, 32'h3F600000, ST_OK,   6};
        v[1] = '{32'h3F800000, 32'h3F800000, 32'h00000000, ST_ZERO, 3};
        v[2] = '{32'h3F800000, 32'hBF800000, 32'h40000000, ST_OK,   5};
        v[3] = '{32'h3F800000, 32'h30800000, 32'h3F800000, ST_OK,   6};
        v[4] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, ST_NAN,  2};
        v[5] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, ST_OVF,  5};
        v[6] = '{32'h00800001, 32'h00800000, 32'h00000000, ST_ZERO, 4};
        v[7] = '{32'hFF800000, 32'h7F800000, 32'hFF800000, ST_OVF,  2};
        v[8] = '{32'h00000000, 32'h80000000, 32'h00000000, ST_ZERO, 2};
        v[9] = '{32'h40400000, 32'h40000000, 32'h3F800000, ST_OK,   5};
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, ans, st, lat);
            n_tests++; if (ans !== v[i].res) begin n_fail++; $display("FAIL dir%0d_answer: got %h expected %h", i, ans, v[i].res); end
            n_tests++; if (st !== v[i].st) begin n_fail++; $display("FAIL dir%0d_status: got %0d expected %0d", i, st, v[i].st); end
            n_tests++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
            release_result();
            n_tests++; if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin n_fail++; $display("FAIL dir%0d_handshake: got vld=%b rdy=%b expected vld=0 rdy=1", i, vld_o, rdy_o); end
        end
    endtask

    task automatic rand_operands(output logic [31:0] a, output logic [31:0] b);
        float_point_num fa, fb;
        fa = $urandom;
        fb = $urandom;
        case ($urandom_range(0, 15))
            0: fa.exp = 8'h00;
            1: fb.exp = 8'h00;
            2: begin fa.exp = 8'hFF; if ($urandom_range(0, 1) == 0) fa.frac = '0; end
            3: begin fb.exp = 8'hFF; if ($urandom_range(0, 1) == 0) fb.frac = '0; end
            4, 5, 6, 7: fb.exp = fa.exp + 8'($urandom_range(0, 2)) - 8'd1;
            8, 9: begin fb.exp = fa.exp; fb.frac = fa.frac ^ 23'($urandom_range(0, 255)); end
            10: fb.exp = fa.exp - 8'($urandom_range(20, 35));
            default: ;
        endcase
        a = fa;
        b = fb;
    endtask

    task automatic test_random();
        logic [31:0] a, b, ans, exp_r;
        fp_status_e  st, exp_st;
        int          lat;
        for (int i = 0; i < 400; i++) begin
            rand_operands(a, b);
            model(a, b, exp_r, exp_st);
            do_op(a, b, ans, st, lat);
            n_tests++; if (ans !== exp_r) begin n_fail++; $display("FAIL rand%0d_answer: %h - %h got %h expected %h", i, a, b, ans, exp_r); end
            n_tests++; if (st !== exp_st) begin n_fail++; $display("FAIL rand%0d_status: %h - %h got %0d expected %0d", i, a, b, st, exp_st); end
            n_tests++; if (lat < 2 || lat > LAT_MAX) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected 2..%0d", i, lat, LAT_MAX); end
            release_result();
        end
    endtask

    task automatic test_hold();
        logic [31:0] ans, exp_r;
        fp_status_e  st, exp_st;
        int          lat;
        model(32'h40400000, 32'h3F800000, exp_r, exp_st);
        do_op(32'h40400000, 32'h3F800000, ans, st, lat);
        for (int i = 0; i < 10; i++) begin
            vld_i = 1'b1;
            a_i   = $urandom;
            b_i   = $urandom;
            @(posedge clk); #1;
            n_tests++; if (answer_o !== exp_r || answer_status_o !== exp_st) begin n_fail++; $display("FAIL hold%0d_answer: got %h/%0d expected %h/%0d", i, answer_o, answer_status_o, exp_r, exp_st); end
            n_tests++; if (vld_o !== 1'b1 || rdy_o !== 1'b0) begin n_fail++; $display("FAIL hold%0d_flags: got vld=%b rdy=%b expected vld=1 rdy=0", i, vld_o, rdy_o); end
        end
        vld_i = 1'b0;
        release_result();
        n_tests++; if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin n_fail++; $display("FAIL hold_release: got vld=%b rdy=%b expected vld=0 rdy=1", vld_o, rdy_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ans, exp_r;
        fp_status_e  st, exp_st;
        int          lat;
        // 1.0 - (1.0 - 2^-24) cancels deeply, so many normalisation cycles follow
        a_i   = 32'h3F800000;
        b_i   = 32'h3F7FFFFF;
        vld_i = 1'b1;
        @(posedge clk); #1;
        vld_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (vld_o !== 1'b0 || rdy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got vld=%b rdy=%b expected vld=0 rdy=0", vld_o, rdy_o); end
        #2 rst_i = 1'b1;
        #1;
        n_tests++; if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_flags: got vld=%b rdy=%b expected vld=0 rdy=1", vld_o, rdy_o); end
        n_tests++; if (answer_o !== 32'h0) begin n_fail++; $display("FAIL midrst_answer: got %h expected 00000000", answer_o); end
        rst_i = 1'b0;
        @(posedge clk); #1;
        model(32'h3F800000, 32'h3F7FFFFF, exp_r, exp_st);
        do_op(32'h3F800000, 32'h3F7FFFFF, ans, st, lat);
        n_tests++; if (ans !== exp_r || st !== exp_st) begin n_fail++; $display("FAIL midrst_recover: got %h/%0d expected %h/%0d", ans, st, exp_r, exp_st); end
        n_tests++; if (lat < 2 || lat > LAT_MAX) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 2..%0d", lat, LAT_MAX); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
